// File: rtl/mem_bus_arbiter.sv
// CPU/DMA/PPU arbiter onto a single memory-controller port (IDLE -> ACCESS -> ACK).
// Optional wait-state counter and ws_cfg port: define GBA_ARB_WAITSTATE_EN.

module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              dma_req,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic              cpu_we,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_ack,
  output logic              dma_ack,
  output logic              ppu_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
`ifdef GBA_ARB_WAITSTATE_EN
  input  logic [3:0]        ws_cfg,
`endif
  output logic [1:0]        bus_owner,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_e;

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_CPU    = 2'd1;
  localparam logic [1:0] OWN_DMA    = 2'd2;
  localparam logic [1:0] OWN_PPU    = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        starve_q, starve_d;
  logic [1:0]        win;
  logic              wait_done;

`ifdef GBA_ARB_WAITSTATE_EN
  logic [3:0]        wait_q, wait_d;
  assign wait_done = (wait_q == 4'd0);
`else
  assign wait_done = 1'b1;
`endif

  // PPU always wins; a starved CPU jumps ahead of DMA but never the PPU
  always_comb begin
    win = OWN_NONE;
    if (ppu_req)
      win = OWN_PPU;
    else if (cpu_req && (!dma_req || starve_q == STARVE_LIM))
      win = OWN_CPU;
    else if (dma_req)
      win = OWN_DMA;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
`ifdef GBA_ARB_WAITSTATE_EN
    wait_d   = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win != OWN_NONE) begin
          owner_d = win;
          state_d = S_ACCESS;
`ifdef GBA_ARB_WAITSTATE_EN
          wait_d  = ws_cfg;
`endif
          case (win)
            OWN_CPU: begin
              addr_d  = cpu_addr;
              we_d    = cpu_we;
              wdata_d = cpu_wdata;
            end
            OWN_DMA: begin
              addr_d  = dma_addr;
              we_d    = dma_we;
              wdata_d = dma_wdata;
            end
            default: begin
              addr_d  = ppu_addr;
              we_d    = 1'b0;
              wdata_d = '0;
            end
          endcase
          if (win == OWN_CPU)
            starve_d = 4'd0;
          else if (cpu_req && starve_q != STARVE_LIM)
            starve_d = starve_q + 4'd1;
        end
      end
      S_ACCESS: begin
        if (mem_ready && wait_done) begin
          if (!we_q)
            rdata_d = mem_rdata;
          state_d = S_ACK;
        end
`ifdef GBA_ARB_WAITSTATE_EN
        else if (!wait_done)
          wait_d = wait_q - 4'd1;
`endif
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
    end
  end

`ifdef GBA_ARB_WAITSTATE_EN
  always_ff @(posedge clk) begin
    if (reset) wait_q <= 4'd0;
    else       wait_q <= wait_d;
  end
`endif

  // Memory port is only driven while a transfer is in flight
  assign mem_read  = (state_q == S_ACCESS) && !we_q;
  assign mem_write = (state_q == S_ACCESS) &&  we_q;
  assign mem_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
  assign mem_wdata = (state_q == S_ACCESS) ? wdata_q : '0;

  assign cpu_ack   = (state_q == S_ACK) && (owner_q == OWN_CPU);
  assign dma_ack   = (state_q == S_ACK) && (owner_q == OWN_DMA);
  assign ppu_ack   = (state_q == S_ACK) && (owner_q == OWN_PPU);

  assign bus_owner = (state_q == S_IDLE) ? OWN_NONE : owner_q;
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level reference model.

module tb_mem_bus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, dma_req, ppu_req;
  logic [AW-1:0] cpu_addr, dma_addr, ppu_addr;
  logic          cpu_we, dma_we;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_ack, dma_ack, ppu_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef GBA_ARB_WAITSTATE_EN
  logic [3:0]    ws_cfg;
`endif
  logic [1:0]    bus_owner;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .dma_req(dma_req), .ppu_req(ppu_req),
    .cpu_addr(cpu_addr), .dma_addr(dma_addr), .ppu_addr(ppu_addr),
    .cpu_we(cpu_we), .dma_we(dma_we),
    .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_ack(cpu_ack), .dma_ack(dma_ack), .ppu_ack(ppu_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef GBA_ARB_WAITSTATE_EN
    .ws_cfg(ws_cfg),
`endif
    .bus_owner(bus_owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: phase 0 = no transfer, 1 = memory access, 2 = completion
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_starve = 0;
  int          m_ws = 0;
  logic [AW-1:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit          m_valid = 1'b0;

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_owner = 0; m_starve = 0; m_ws = 0; m_rdata = '0; m_valid = 1'b1;
    end else if (m_phase == 0) begin
      if (ppu_req || dma_req || cpu_req) begin
        if (ppu_req)                                     m_owner = 3;
        else if (cpu_req && (!dma_req || m_starve == SMAX)) m_owner = 1;
        else                                             m_owner = 2;
        if (m_owner == 1)  m_starve = 0;
        else if (cpu_req)  m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        case (m_owner)
          1:       begin m_addr = cpu_addr; m_we = cpu_we; m_wdata = cpu_wdata; end
          2:       begin m_addr = dma_addr; m_we = dma_we; m_wdata = dma_wdata; end
          default: begin m_addr = ppu_addr; m_we = 1'b0;   m_wdata = '0;        end
        endcase
`ifdef GBA_ARB_WAITSTATE_EN
        m_ws = int'(ws_cfg);
`else
        m_ws = 0;
`endif
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ready && m_ws == 0) begin
        if (!m_we) m_rdata = mem_rdata;
        m_phase = 2;
      end else if (m_ws > 0) begin
        m_ws = m_ws - 1;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("busy",  busy, m_phase != 0);
      chk("owner", bus_owner, (m_phase != 0) ? m_owner : 0);
      chk("acks",  {cpu_ack, dma_ack, ppu_ack},
          (m_phase == 2) ? {m_owner == 1, m_owner == 2, m_owner == 3} : 3'b000);
      chk("strobes", {mem_read, mem_write}, (m_phase == 1) ? {!m_we, m_we} : 2'b00);
      if (m_phase == 1) chk("mem_addr", mem_addr, m_addr);
      if (m_phase == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("rdata", rdata, m_rdata);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input int who, input int maxc, output int n);
    n = 0;
    for (int k = 0; k < maxc; k++) begin
      tick();
      n++;
      if ((who == 1 && cpu_ack) || (who == 2 && dma_ack) || (who == 3 && ppu_ack)) return;
    end
    n = -1;
  endtask

  initial begin
    int n, p, d, c, n_dma, cw, ca, nw;
    bit got;
    logic [1:0] first;

    reset = 1'b1;
    {cpu_req, dma_req, ppu_req} = 3'b000;
    cpu_addr = '0; dma_addr = '0; ppu_addr = '0;
    {cpu_we, dma_we} = 2'b00;
    cpu_wdata = '0; dma_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
`ifdef GBA_ARB_WAITSTATE_EN
    ws_cfg = 4'd0;
`endif
    tick(); tick();
    chk("rst_busy",  busy, 1'b0);
    chk("rst_owner", bus_owner, 2'd0);
    chk("rst_rdata", rdata, '0);
    chk("rst_maddr", mem_addr, '0);
    chk("rst_mwdata", mem_wdata, '0);
    reset = 1'b0;

    // Single CPU read, minimum latency
    cpu_addr = 32'h0300_0000; cpu_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cpu_req = 1'b1;
    tick();
    chk("030_mem_read", mem_read, 1'b1);
    chk("030_mem_addr", mem_addr, 32'h0300_0000);
    tick();
    chk("030_cpu_ack", cpu_ack, 1'b1);
    chk("030_rdata", rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    tick();

    // Simultaneous requests: PPU, DMA, CPU order, 3 cycles apart
    ppu_addr = 32'h0500_0040; dma_addr = 32'h0200_0000; cpu_addr = 32'h0300_0100;
    {ppu_req, dma_req, cpu_req} = 3'b111;
    p = -1; d = -1; c = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (ppu_ack) begin p = k; ppu_req = 1'b0; end
      if (dma_ack) begin d = k; dma_req = 1'b0; end
      if (cpu_ack) begin c = k; cpu_req = 1'b0; end
    end
    chk("031_ppu_ack_cyc", p, 2);
    chk("031_dma_ack_cyc", d, 5);
    chk("031_cpu_ack_cyc", c, 8);

    // Starvation boost after STARVE_MAX lost arbitrations
    dma_req = 1'b1; cpu_req = 1'b1;
    n_dma = 0; got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      tick();
      if (dma_ack) n_dma++;
      if (cpu_ack) begin got = 1'b1; cpu_req = 1'b0; end
    end
    chk("032_dma_grants", n_dma, SMAX);
    chk("032_cpu_granted", got, 1'b1);
    tick();
    cpu_req = 1'b1;
    first = 2'b00;
    for (int k = 0; k < 10 && first == 2'b00; k++) begin
      tick();
      first = {cpu_ack, dma_ack};
    end
    chk("032_starve_clr", first, 2'b01);
    dma_req = 1'b0;
    wait_ack(1, 20, n);
    chk("032_cpu_done", n > 0, 1'b1);
    cpu_req = 1'b0;
    tick();

    // DMA write stalled by mem_ready for 4 cycles
    dma_addr = 32'h0600_0010; dma_wdata = 32'h1234_5678; dma_we = 1'b1;
    mem_ready = 1'b0; dma_req = 1'b1;
    nw = 0; cw = -1; ca = -1;
    for (int k = 1; k <= 20 && ca < 0; k++) begin
      tick();
      if (mem_write) begin
        nw++; cw = k;
        if (nw == 1) chk("033_wdata", mem_wdata, 32'h1234_5678);
        if (nw == 5) mem_ready = 1'b1;
      end
      if (dma_ack) begin ca = k; dma_req = 1'b0; end
    end
    chk("033_write_cycles", nw, 5);
    chk("033_ack_gap", ca - cw, 1);
    dma_we = 1'b0;
    tick();

    // Reset in the middle of an access aborts it; request then served afresh
    cpu_addr = 32'h0300_0200; cpu_we = 1'b0; mem_ready = 1'b0; cpu_req = 1'b1;
    tick();
    chk("034_in_access", mem_read, 1'b1);
    reset = 1'b1;
    tick();
    chk("034_busy", busy, 1'b0);
    chk("034_strobes", {mem_read, mem_write}, 2'b00);
    chk("034_acks", {cpu_ack, dma_ack, ppu_ack}, 3'b000);
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    wait_ack(1, 10, n);
    chk("034_reserve_lat", n, 2);
    chk("034_rdata", rdata, 32'h0BAD_F00D);
    cpu_req = 1'b0;
    tick();

`ifdef GBA_ARB_WAITSTATE_EN
    ws_cfg = 4'd3; mem_ready = 1'b1; cpu_req = 1'b1;
    wait_ack(1, 15, n);
    chk("035_ws3_lat", n, 5);
    cpu_req = 1'b0; ws_cfg = 4'd0;
    tick();
`endif

    // Random traffic; the per-cycle model comparison does the checking
    repeat (3000) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (cpu_ack) cpu_req = ($urandom_range(0, 3) == 0);
      else if (!cpu_req) cpu_req = ($urandom_range(0, 2) == 0);
      if (dma_ack) dma_req = ($urandom_range(0, 1) == 0);
      else if (!dma_req) dma_req = ($urandom_range(0, 2) == 0);
      if (ppu_ack) ppu_req = ($urandom_range(0, 3) == 0);
      else if (!ppu_req) ppu_req = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cpu_addr = $urandom; cpu_we = $urandom_range(0, 1) == 1; cpu_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        dma_addr = $urandom; dma_we = $urandom_range(0, 1) == 1; dma_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) ppu_addr = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
`ifdef GBA_ARB_WAITSTATE_EN
      ws_cfg = 4'($urandom_range(0, 3));
`endif
    end

    reset = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_MAX, 8, lost CPU arbitrations before CPU priority boost (1..15).
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req, dma_req, ppu_req  input  1 each  access request; held until matching ack.
REQ-005 cpu_addr, dma_addr, ppu_addr  input  ADDR_W each  request address.
REQ-006 cpu_we, dma_we  input  1 each  1=write, 0=read; PPU is read-only.
REQ-007 cpu_wdata, dma_wdata  input  DATA_W each  write data.
REQ-008 cpu_ack, dma_ack, ppu_ack  output  1 each  one-cycle completion pulse.
REQ-009 rdata  output  DATA_W  registered read data; valid in the ack cycle.
REQ-010 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_read, mem_write  output  1 each  shared memory-controller port.
REQ-011 mem_rdata  input  DATA_W; mem_ready  input  1  controller completion.
REQ-012 bus_owner  output  2  0 none, 1 CPU, 2 DMA, 3 PPU; busy  output  1  high when not IDLE.
REQ-013 ws_cfg  input  4  extra wait states; present only with GBA_ARB_WAITSTATE_EN.

Function
REQ-014 FSM SHALL have states IDLE, ACCESS, ACK.
REQ-015 IDLE: if any req high, winner latched (owner, addr, we, wdata); next state ACCESS; else remain IDLE.
REQ-016 Priority SHALL be PPU > DMA > CPU; when starve count == STARVE_MAX, CPU SHALL outrank DMA, never PPU.
REQ-017 Starve count SHALL increment (saturating at STARVE_MAX) per IDLE arbitration where cpu_req is high and CPU loses; clear to 0 when CPU granted.
REQ-018 ACCESS: mem_addr/mem_wdata SHALL drive latched values; exactly one of mem_read/mem_write high per latched we (PPU always read).
REQ-019 ACCESS completes on first cycle mem_ready=1 with wait counter 0; rdata captures mem_rdata on reads, holds on writes; next state ACK.
REQ-020 ACK: owner's ack high one cycle, strobes low; next state IDLE.
REQ-021 Minimum latency: req sampled cycle N, strobes cycle N+1, ack cycle N+2 if mem_ready high at N+1.
REQ-022 Requester SHALL drop req the cycle after ack; a req still high in IDLE is a new request.
REQ-023 Requests changing while not granted SHALL be ignored until next IDLE; latched fields SHALL not change in ACCESS/ACK.
REQ-024 bus_owner SHALL equal latched owner in ACCESS/ACK, 0 in IDLE.
REQ-025 mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-026 reset SHALL force IDLE, all acks/strobes 0, bus_owner 0, busy 0, rdata 0, mem_addr/mem_wdata 0, starve count 0, wait counter 0.
REQ-027 reset during ACCESS/ACK SHALL abort the transfer the next cycle with no ack issued.

Configuration
REQ-028 With GBA_ARB_WAITSTATE_EN defined, entering ACCESS SHALL load wait counter from ws_cfg, decrement per ACCESS cycle, and gate mem_ready until 0 (ws_cfg=3 adds 3 cycles).
REQ-029 Without GBA_ARB_WAITSTATE_EN, ws_cfg port and counter SHALL not exist; ACCESS completes on first mem_ready.

Verification
REQ-030 cpu_req read addr 0x0300_0000, mem_ready=1, mem_rdata=0xDEAD_BEEF -> mem_read at N+1, cpu_ack and rdata=0xDEAD_BEEF at N+2.
REQ-031 ppu_req, dma_req, cpu_req same cycle, all held -> acks in order PPU, DMA, CPU, each 3 cycles apart.
REQ-032 dma_req held continuously, cpu_req high -> CPU granted on 9th arbitration (STARVE_MAX=8), starve count back to 0.
REQ-033 dma write 0x0600_0010 data 0x1234_5678, mem_ready low 4 cycles -> mem_write held 5 cycles, dma_ack one cycle after mem_ready.
REQ-034 reset asserted in ACCESS -> next cycle IDLE, strobes 0, no ack; later cpu_req served normally.
REQ-035 GBA_ARB_WAITSTATE_EN, ws_cfg=3, mem_ready tied 1 -> ack at N+5.
